// File: rtl/cwe_1262_trap_unit_pkg.sv
// Shared constants and FSM encoding for the privilege-check trap unit.
package cwe_1262_pkg;

  localparam logic [1:0]  MACHINE_PRIV      = 2'b11;
  localparam logic [1:0]  USER_PRIV         = 2'b00;
  localparam logic [11:0] STACK_REG         = 12'h064;
  localparam logic [3:0]  CAUSE_ILLEGAL_CSR = 4'd2;

  typedef enum logic [1:0] {
    IDLE,
    TRAP_REDIR,
    HANDLER,
    RET_REDIR
  } trap_state_e;

endpackage

// File: rtl/cwe_1262_trap_unit_if.sv
// Exception, redirect and trap-CSR signals between the trap unit (slave) and its
// environment: privilege checker, fetch and handler (master).
interface cwe_1262_trap_unit_if;

  logic        except;
  logic [31:0] fault_pc;
  logic [11:0] fault_addr;
  logic        mret;
  logic        redirect_ready;
  logic [1:0]  priv_state;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] mepc;
  logic [11:0] mtval;
  logic [3:0]  mcause;
  logic        busy;

  modport master (
    output except, fault_pc, fault_addr, mret, redirect_ready,
    input  priv_state, redirect_valid, redirect_pc, flush, mepc, mtval, mcause, busy
  );

  modport slave (
    input  except, fault_pc, fault_addr, mret, redirect_ready,
    output priv_state, redirect_valid, redirect_pc, flush, mepc, mtval, mcause, busy
  );

endinterface

// File: rtl/cwe_1262_trap_unit_redirect_reg.sv
// Valid/ready holding register for fetch redirects: load a target, hold it until
// accepted, then drop valid. The target itself stays put after the handshake.
module cwe_1262_redirect_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_pc,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_pc;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;

endmodule

// File: rtl/cwe_1262_trap_unit.sv
// Trap entry/return controller for illegal CSR accesses; owns priv_state.
// Optional saturating trap counter enabled by defining CWE1262_TRAP_COUNT_EN.
module cwe_1262_trap_unit
  import cwe_1262_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter logic [31:0] MEPC_INC    = 32'd4,
  parameter logic [1:0]  RESET_PRIV  = USER_PRIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cwe_1262_trap_unit_if.slave   bus
`ifdef CWE1262_TRAP_COUNT_EN
  ,
  output logic [15:0]           trap_count
`endif
);

  trap_state_e r_state;
  trap_state_e w_next_state;

  logic        w_trap_entry;
  logic        w_ret_entry;
  logic        w_load;
  logic [31:0] w_load_pc;
  logic        w_handshake;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;

  logic [1:0]  r_priv;
  logic [1:0]  r_mpp;
  logic [31:0] r_mepc;
  logic [11:0] r_mtval;
  logic [3:0]  r_mcause;
  logic        r_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  assign w_handshake = w_redirect_valid & bus.redirect_ready;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:       if (bus.except) w_next_state = TRAP_REDIR;
      TRAP_REDIR: if (w_handshake) w_next_state = HANDLER;
      HANDLER:    if (bus.mret)   w_next_state = RET_REDIR;
      RET_REDIR:  if (w_handshake) w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // except beats mret in IDLE simply because mret is only honoured in HANDLER.
  always_comb begin
    w_trap_entry = (r_state == IDLE) && bus.except;
    w_ret_entry  = (r_state == HANDLER) && bus.mret;
    w_load       = w_trap_entry || w_ret_entry;
    w_load_pc    = w_trap_entry ? TRAP_VECTOR : (r_mepc + MEPC_INC);
  end

  cwe_1262_redirect_reg u_redirect (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_pc    (w_load_pc),
    .i_ready (bus.redirect_ready),
    .o_valid (w_redirect_valid),
    .o_pc    (w_redirect_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_priv   <= RESET_PRIV;
      r_mpp    <= RESET_PRIV;
      r_mepc   <= '0;
      r_mtval  <= '0;
      r_mcause <= '0;
      r_flush  <= 1'b0;
    end else begin
      r_flush <= w_load;
      if (w_trap_entry) begin
        r_mepc   <= bus.fault_pc;
        r_mtval  <= bus.fault_addr;
        r_mcause <= CAUSE_ILLEGAL_CSR;
        r_mpp    <= r_priv;
        r_priv   <= MACHINE_PRIV;
      end else if (w_ret_entry) begin
        r_priv   <= r_mpp;
      end
    end
  end

`ifdef CWE1262_TRAP_COUNT_EN
  logic [15:0] r_trap_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_trap_count <= '0;
    else if (w_trap_entry && r_trap_count != 16'hFFFF) r_trap_count <= r_trap_count + 16'd1;
  end

  assign trap_count = r_trap_count;
`endif

  assign bus.priv_state     = r_priv;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.flush          = r_flush;
  assign bus.mepc           = r_mepc;
  assign bus.mtval          = r_mtval;
  assign bus.mcause         = r_mcause;
  assign bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_cwe_1262_trap_unit.sv
// Scoreboard bench for cwe_1262_trap_unit: the driver predicts each redirect from
// a trap/return model, the monitor checks every accepted redirect and flush.
module tb_cwe_1262_trap_unit;
  import cwe_1262_pkg::*;

  localparam logic [31:0] TV = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  priv;
    logic [31:0] mepc;
    logic [11:0] mtval;
    logic [3:0]  mcause;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cwe_1262_trap_unit_if bus ();
`ifdef CWE1262_TRAP_COUNT_EN
  logic [15:0] trap_count;
`endif

  cwe_1262_trap_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CWE1262_TRAP_COUNT_EN
    ,
    .trap_count (trap_count)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   hs_count = 0;
  exp_t sb[$];

  // Reference model of the architectural trap state.
  logic [1:0]  m_priv;
  logic [1:0]  m_mpp;
  logic [31:0] m_mepc;
  logic [11:0] m_mtval;
  logic [3:0]  m_mcause;
  logic [15:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_priv = USER_PRIV; m_mpp = USER_PRIV;
    m_mepc = '0; m_mtval = '0; m_mcause = '0; m_count = '0;
    sb.delete();
  endtask

  // Monitor: flush must coincide with the first cycle of each redirect, the
  // target must hold while waiting, and accepted redirects must match the model.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("flush_pulse", {31'd0, bus.flush}, {31'd0, bus.redirect_valid && !prev_valid});
      if (bus.redirect_valid && prev_valid) check("pc_hold", bus.redirect_pc, prev_pc);
      if (bus.redirect_valid && bus.redirect_ready) begin
        hs_count++;
        if (sb.size() == 0) begin
          check("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("hs_pc",     bus.redirect_pc, e.pc);
          check("hs_priv",   {30'd0, bus.priv_state}, {30'd0, e.priv});
          check("hs_mepc",   bus.mepc, e.mepc);
          check("hs_mtval",  {20'd0, bus.mtval}, {20'd0, e.mtval});
          check("hs_mcause", {28'd0, bus.mcause}, {28'd0, e.mcause});
        end
      end
      prev_valid = bus.redirect_valid;
      prev_pc    = bus.redirect_pc;
    end
  end

  // Waits for one accepted redirect; ready low for the first `hold` cycles,
  // stray except pulses in between must be ignored.
  task automatic wait_hs(input int hold, input bit rnd);
    int start = hs_count;
    int n = 0;
    while (hs_count == start && n < 64) begin
      if (n < hold)     bus.redirect_ready = 1'b0;
      else if (rnd)     bus.redirect_ready = ($urandom_range(0, 2) != 0) || (n > hold + 4);
      else              bus.redirect_ready = 1'b1;
      bus.except     = ($urandom_range(0, 2) == 0);
      bus.fault_pc   = $urandom;
      bus.fault_addr = 12'($urandom);
      tick();
      bus.except = 1'b0;
      n++;
    end
    bus.redirect_ready = 1'b0;
    check("handshake_seen", {31'd0, hs_count != start}, 32'd1);
  endtask

  task automatic do_trap(input logic [31:0] pc, input logic [11:0] addr,
                         input bit with_mret, input int hold, input bit rnd);
    sb.push_back('{pc: TV, priv: MACHINE_PRIV, mepc: pc, mtval: addr, mcause: CAUSE_ILLEGAL_CSR});
    m_mpp = m_priv; m_priv = MACHINE_PRIV;
    m_mepc = pc; m_mtval = addr; m_mcause = CAUSE_ILLEGAL_CSR;
    if (m_count != 16'hFFFF) m_count++;
    bus.except = 1'b1; bus.mret = with_mret;
    bus.fault_pc = pc; bus.fault_addr = addr;
    bus.redirect_ready = (hold == 0) && !rnd;
    tick();
    bus.except = 1'b0; bus.mret = 1'b0;
    check("entry_flush", {31'd0, bus.flush}, 32'd1);
    check("entry_valid", {31'd0, bus.redirect_valid}, 32'd1);
    check("entry_pc",    bus.redirect_pc, TV);
    check("entry_priv",  {30'd0, bus.priv_state}, {30'd0, MACHINE_PRIV});
    check("entry_mepc",  bus.mepc, pc);
    check("entry_mtval", {20'd0, bus.mtval}, {20'd0, addr});
    wait_hs(hold, rnd);
    check("busy_handler", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic do_ret(input int hold, input bit rnd);
    logic [31:0] tgt;
    int idle = $urandom_range(0, 3);
    for (int i = 0; i < idle; i++) begin
      bus.except = ($urandom_range(0, 1) == 0);
      bus.fault_pc = $urandom; bus.fault_addr = 12'($urandom);
      tick();
      bus.except = 1'b0;
    end
    tgt = m_mepc + 32'd4;
    sb.push_back('{pc: tgt, priv: m_mpp, mepc: m_mepc, mtval: m_mtval, mcause: m_mcause});
    m_priv = m_mpp;
    bus.mret = 1'b1;
    bus.redirect_ready = (hold == 0) && !rnd;
    tick();
    bus.mret = 1'b0;
    check("ret_priv",  {30'd0, bus.priv_state}, {30'd0, m_priv});
    check("ret_pc",    bus.redirect_pc, tgt);
    check("ret_flush", {31'd0, bus.flush}, 32'd1);
    wait_hs(hold, rnd);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_idle_regs(input string tag);
    check({tag, "_priv"},   {30'd0, bus.priv_state}, {30'd0, m_priv});
    check({tag, "_valid"},  {31'd0, bus.redirect_valid}, 32'd0);
    check({tag, "_flush"},  {31'd0, bus.flush}, 32'd0);
    check({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
    check({tag, "_mepc"},   bus.mepc, m_mepc);
    check({tag, "_mtval"},  {20'd0, bus.mtval}, {20'd0, m_mtval});
    check({tag, "_mcause"}, {28'd0, bus.mcause}, {28'd0, m_mcause});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.except = 1'b0; bus.mret = 1'b0; bus.redirect_ready = 1'b0;
    bus.fault_pc = '0; bus.fault_addr = '0;
    model_reset();
    #23;
    check_idle_regs("reset");
    check("reset_pc", bus.redirect_pc, 32'd0);
    rst_n = 1'b1;
    tick();
    check_idle_regs("post_reset");

    // Directed trap entry with ready already high, then return.
    do_trap(32'h0000_2000, STACK_REG, 1'b0, 0, 1'b0);
    do_ret(0, 1'b0);
    // Backpressure for five cycles with ignored except pulses.
    do_trap($urandom & 32'hFFFF_FFFC, 12'($urandom), 1'b0, 5, 1'b0);
    do_ret(3, 1'b1);
    // Return target wraps past 2^32.
    do_trap(32'hFFFF_FFFC, 12'h300, 1'b0, 1, 1'b1);
    do_ret(0, 1'b1);
    // except and mret together in IDLE: trap wins.
    do_trap(32'h0000_4440, 12'h7C0, 1'b1, 0, 1'b1);
    do_ret(2, 1'b1);

    // mret in IDLE is ignored.
    bus.mret = 1'b1;
    tick();
    bus.mret = 1'b0;
    tick();
    check_idle_regs("idle_mret");

    for (int i = 0; i < 20; i++) begin
      do_trap($urandom, 12'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b1);
      do_ret($urandom_range(0, 4), 1'b1);
    end

`ifdef CWE1262_TRAP_COUNT_EN
    check("count_value", {16'd0, trap_count}, {16'd0, m_count});
`endif

    // Reset in the middle of a held trap redirect.
    sb.push_back('{pc: TV, priv: MACHINE_PRIV, mepc: 32'h1234, mtval: 12'h111, mcause: CAUSE_ILLEGAL_CSR});
    bus.except = 1'b1; bus.fault_pc = 32'h1234; bus.fault_addr = 12'h111;
    bus.redirect_ready = 1'b0;
    tick();
    bus.except = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_idle_regs("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle_regs("after_reset");
    do_trap(32'h0000_8000, 12'h064, 1'b0, 2, 1'b1);
    do_ret(1, 1'b1);

`ifdef CWE1262_TRAP_COUNT_EN
    check("count_after_reset", {16'd0, trap_count}, {16'd0, m_count});
    force dut.r_trap_count = 16'hFFFD;
    tick();
    release dut.r_trap_count;
    m_count = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      do_trap($urandom, 12'($urandom), 1'b0, 0, 1'b1);
      do_ret(0, 1'b1);
    end
    check("count_saturate", {16'd0, trap_count}, {16'd0, m_count});
`endif

    tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
